// File: rtl/sc_regpoint_cmdgen.sv
// Command generator for the one-hot point register: turns left/right/start requests into
// single-cycle shift/clear commands with edge suppression and hold-to-repeat.
//
// state  | meaning
// IDLE   | no request being serviced; a new press is evaluated here
// HOLD_L | left held after a step toward MSB; counting to the next repeat
// HOLD_R | right held after a step toward LSB; counting to the next repeat
// CLEAR  | clear issued; waiting for start release
module sc_regpoint_cmdgen #(
    parameter int RegPOINTCMD_DATAWIDTH   = 8,
    parameter int RegPOINTCMD_REPEATDELAY = 25000000,
    parameter int RegPOINTCMD_REPEATRATE  = 12500000,
    parameter int RegPOINTCMD_COUNTWIDTH  = 25
) (
    input  logic                             SC_RegPOINTCMD_CLOCK_50,
    input  logic                             SC_RegPOINTCMD_RESET_InLow,
    input  logic                             SC_RegPOINTCMD_left_InLow,
    input  logic                             SC_RegPOINTCMD_right_InLow,
    input  logic                             SC_RegPOINTCMD_start_InLow,
    input  logic [RegPOINTCMD_DATAWIDTH-1:0] SC_RegPOINTCMD_point_InBUS,
    output logic [1:0]                       SC_RegPOINTCMD_shiftselection_Out,
    output logic                             SC_RegPOINTCMD_clear_OutLow,
    output logic                             SC_RegPOINTCMD_blocked_Out
);

    typedef enum logic [1:0] {IDLE, HOLD_L, HOLD_R, CLEAR} stateType;

    localparam logic [1:0] SHIFT_NONE = 2'b00;
    localparam logic [1:0] SHIFT_MSB  = 2'b01;
    localparam logic [1:0] SHIFT_LSB  = 2'b10;

    localparam logic [RegPOINTCMD_COUNTWIDTH-1:0] DELAY_LOAD =
        RegPOINTCMD_COUNTWIDTH'(RegPOINTCMD_REPEATDELAY - 1);
    localparam logic [RegPOINTCMD_COUNTWIDTH-1:0] RATE_LOAD =
        RegPOINTCMD_COUNTWIDTH'(RegPOINTCMD_REPEATRATE - 1);
    localparam logic [RegPOINTCMD_COUNTWIDTH-1:0] COUNT_ONE = RegPOINTCMD_COUNTWIDTH'(1);
    localparam logic [RegPOINTCMD_DATAWIDTH-1:0]  POINT_ONE = RegPOINTCMD_DATAWIDTH'(1);

    stateType                          stateReg, stateNext;
    logic [RegPOINTCMD_COUNTWIDTH-1:0] counterReg, counterNext;
    logic [1:0]                        shiftReg, shiftNext;
    logic                              clearReg, clearNext;
    logic                              blockedReg, blockedNext;

    logic startReq, leftOnly, rightOnly;
    logic pointOneHot, canMsb, canLsb;

    assign startReq  = ~SC_RegPOINTCMD_start_InLow;
    assign leftOnly  = ~SC_RegPOINTCMD_left_InLow & SC_RegPOINTCMD_right_InLow;
    assign rightOnly = SC_RegPOINTCMD_left_InLow & ~SC_RegPOINTCMD_right_InLow;

    // A corrupted readback (zero or several bits) blocks both directions.
    assign pointOneHot = (SC_RegPOINTCMD_point_InBUS != '0) &&
                         ((SC_RegPOINTCMD_point_InBUS &
                           (SC_RegPOINTCMD_point_InBUS - POINT_ONE)) == '0);
    assign canMsb = pointOneHot & ~SC_RegPOINTCMD_point_InBUS[RegPOINTCMD_DATAWIDTH-1];
    assign canLsb = pointOneHot & ~SC_RegPOINTCMD_point_InBUS[0];

    always_ff @(posedge SC_RegPOINTCMD_CLOCK_50 or negedge SC_RegPOINTCMD_RESET_InLow) begin
        if (!SC_RegPOINTCMD_RESET_InLow) begin
            stateReg   <= IDLE;
            counterReg <= '0;
            shiftReg   <= SHIFT_NONE;
            clearReg   <= 1'b1;
            blockedReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            counterReg <= counterNext;
            shiftReg   <= shiftNext;
            clearReg   <= clearNext;
            blockedReg <= blockedNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        counterNext = counterReg;
        shiftNext   = SHIFT_NONE;
        clearNext   = 1'b1;
        blockedNext = 1'b0;
        unique case (stateReg)
            IDLE: begin
                counterNext = '0;
                if (startReq) begin
                    stateNext = CLEAR;
                    clearNext = 1'b0;
                end else if (leftOnly) begin
                    stateNext   = HOLD_L;
                    counterNext = DELAY_LOAD;
                    if (canMsb) shiftNext = SHIFT_MSB;
                    else        blockedNext = 1'b1;
                end else if (rightOnly) begin
                    stateNext   = HOLD_R;
                    counterNext = DELAY_LOAD;
                    if (canLsb) shiftNext = SHIFT_LSB;
                    else        blockedNext = 1'b1;
                end
            end
            HOLD_L: begin
                if (startReq) begin
                    stateNext   = CLEAR;
                    counterNext = '0;
                    clearNext   = 1'b0;
                end else if (leftOnly) begin
                    if (counterReg == '0) begin
                        counterNext = RATE_LOAD;
                        if (canMsb) shiftNext = SHIFT_MSB;
                        else        blockedNext = 1'b1;
                    end else begin
                        counterNext = counterReg - COUNT_ONE;
                    end
                end else begin
                    stateNext   = IDLE;
                    counterNext = '0;
                end
            end
            HOLD_R: begin
                if (startReq) begin
                    stateNext   = CLEAR;
                    counterNext = '0;
                    clearNext   = 1'b0;
                end else if (rightOnly) begin
                    if (counterReg == '0) begin
                        counterNext = RATE_LOAD;
                        if (canLsb) shiftNext = SHIFT_LSB;
                        else        blockedNext = 1'b1;
                    end else begin
                        counterNext = counterReg - COUNT_ONE;
                    end
                end else begin
                    stateNext   = IDLE;
                    counterNext = '0;
                end
            end
            CLEAR: begin
                counterNext = '0;
                if (!startReq) stateNext = IDLE;
            end
            default: begin
                stateNext   = IDLE;
                counterNext = '0;
            end
        endcase
    end

    assign SC_RegPOINTCMD_shiftselection_Out = shiftReg;
    assign SC_RegPOINTCMD_clear_OutLow       = clearReg;
    assign SC_RegPOINTCMD_blocked_Out        = blockedReg;

endmodule

// File: tb/tb_sc_regpoint_cmdgen.sv
// Bench for sc_regpoint_cmdgen with a behavioural point register closing the readback loop.
// Expected outputs are queued as each cycle's stimulus is applied and popped after the edge.
module tb_sc_regpoint_cmdgen;

    localparam logic [3:0] O_IDLE = 4'b0010;  // {shift, clear_n, blocked}
    localparam logic [3:0] O_L    = 4'b0110;
    localparam logic [3:0] O_R    = 4'b1010;
    localparam logic [3:0] O_BLK  = 4'b0011;
    localparam logic [3:0] O_CLR  = 4'b0000;

    logic       clk = 1'b0;
    logic       rstN = 1'b1;
    logic       leftN = 1'b1, rightN = 1'b1, startN = 1'b1;
    logic [7:0] pointReg = 8'h01;
    logic [7:0] presetVal = 8'h01;
    logic       presetEn = 1'b0;
    logic [1:0] shift;
    logic       clearN, blocked;

    int checks = 0;
    int errors = 0;
    logic [3:0] expQ[$];
    string      tagQ[$];

    sc_regpoint_cmdgen #(
        .RegPOINTCMD_DATAWIDTH(8),
        .RegPOINTCMD_REPEATDELAY(4),
        .RegPOINTCMD_REPEATRATE(2),
        .RegPOINTCMD_COUNTWIDTH(4)
    ) dut (
        .SC_RegPOINTCMD_CLOCK_50(clk),
        .SC_RegPOINTCMD_RESET_InLow(rstN),
        .SC_RegPOINTCMD_left_InLow(leftN),
        .SC_RegPOINTCMD_right_InLow(rightN),
        .SC_RegPOINTCMD_start_InLow(startN),
        .SC_RegPOINTCMD_point_InBUS(pointReg),
        .SC_RegPOINTCMD_shiftselection_Out(shift),
        .SC_RegPOINTCMD_clear_OutLow(clearN),
        .SC_RegPOINTCMD_blocked_Out(blocked)
    );

    always #5 clk = ~clk;

    // Point register: clear returns to 00000001.
    always @(posedge clk) begin
        if (presetEn)          pointReg <= presetVal;
        else if (!clearN)      pointReg <= 8'h01;
        else if (shift == 2'b01) pointReg <= {pointReg[6:0], 1'b0};
        else if (shift == 2'b10) pointReg <= {1'b0, pointReg[7:1]};
    end

    task automatic checkResult(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input logic l, input logic r, input logic s, input logic [3:0] exp,
                       input string tag);
        leftN = l; rightN = r; startN = s;
        expQ.push_back(exp);
        tagQ.push_back(tag);
        @(posedge clk); #1;
        checkResult(tagQ.pop_front(), {28'd0, shift, clearN, blocked}, {28'd0, expQ.pop_front()});
    endtask

    task automatic preset(input logic [7:0] v);
        leftN = 1'b1; rightN = 1'b1; startN = 1'b1;
        presetVal = v; presetEn = 1'b1;
        @(posedge clk); #1;
        presetEn = 1'b0;
    endtask

    initial begin
        #1 rstN = 1'b0;
        #1;
        checkResult("reset_out", {28'd0, shift, clearN, blocked}, {28'd0, O_IDLE});
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        cyc(1, 1, 1, O_IDLE, "idle");

        // single press
        preset(8'h08);
        cyc(0, 1, 1, O_L, "single_step");
        cyc(1, 1, 1, O_IDLE, "single_after");
        checkResult("single_point", {24'd0, pointReg}, 32'h10);

        // edge and corrupted-readback blocks
        preset(8'h80);
        cyc(0, 1, 1, O_BLK, "blk_msb");
        cyc(1, 1, 1, O_IDLE, "blk_msb_after");
        checkResult("blk_msb_point", {24'd0, pointReg}, 32'h80);
        preset(8'h01);
        cyc(1, 0, 1, O_BLK, "blk_lsb");
        cyc(1, 1, 1, O_IDLE, "blk_lsb_after");
        preset(8'h00);
        cyc(0, 1, 1, O_BLK, "blk_zero");
        cyc(1, 1, 1, O_IDLE, "blk_zero_after");
        preset(8'h18);
        cyc(1, 0, 1, O_BLK, "blk_multi");
        cyc(1, 1, 1, O_IDLE, "blk_multi_after");

        // auto-repeat: steps launched at held cycles 0,4,6,8,10
        preset(8'h01);
        for (int k = 0; k < 12; k++)
            cyc(0, 1, 1, (k == 0 || (k >= 4 && k[0] == 1'b0)) ? O_L : O_IDLE,
                $sformatf("repeat_%0d", k));
        cyc(1, 1, 1, O_IDLE, "repeat_release");
        checkResult("repeat_point", {24'd0, pointReg}, 32'h20);

        // conflicts
        preset(8'h08);
        cyc(0, 0, 1, O_IDLE, "both_idle0");
        cyc(0, 0, 1, O_IDLE, "both_idle1");
        cyc(0, 1, 1, O_L, "conf_left");
        cyc(0, 0, 1, O_IDLE, "conf_both_exit");
        cyc(1, 0, 1, O_R, "conf_right_from_idle");
        cyc(1, 1, 1, O_IDLE, "conf_release");
        checkResult("conf_point", {24'd0, pointReg}, 32'h08);

        // start priority
        cyc(0, 1, 1, O_L, "start_left");
        cyc(0, 1, 1, O_IDLE, "start_hold");
        cyc(0, 1, 0, O_CLR, "start_clear");
        cyc(0, 1, 0, O_IDLE, "start_wait");
        cyc(0, 1, 1, O_IDLE, "start_release");
        cyc(0, 1, 1, O_L, "start_left_again");
        cyc(1, 1, 1, O_IDLE, "start_done");
        checkResult("start_point", {24'd0, pointReg}, 32'h02);
        cyc(1, 1, 0, O_CLR, "idle_clear");
        cyc(1, 1, 1, O_IDLE, "idle_clear_rel");

        // reset mid-hold kills the live step before the register can take it
        preset(8'h08);
        cyc(1, 0, 1, O_R, "rst_step");
        #2 rstN = 1'b0;
        #1;
        checkResult("rst_hold_out", {28'd0, shift, clearN, blocked}, {28'd0, O_IDLE});
        @(posedge clk); #1;
        checkResult("rst_hold_stay", {28'd0, shift, clearN, blocked}, {28'd0, O_IDLE});
        rstN = 1'b1;
        cyc(1, 0, 1, O_R, "rst_rel_step");
        cyc(1, 1, 1, O_IDLE, "rst_rel_done");
        checkResult("rst_point", {24'd0, pointReg}, 32'h04);

        // reset mid-clear
        cyc(1, 1, 0, O_CLR, "rst_clr");
        #2 rstN = 1'b0;
        #1;
        checkResult("rst_clr_out", {28'd0, shift, clearN, blocked}, {28'd0, O_IDLE});
        startN = 1'b1;
        @(posedge clk); #1;
        rstN = 1'b1;
        cyc(1, 1, 1, O_IDLE, "rst_clr_idle");
        checkResult("rst_clr_point", {24'd0, pointReg}, 32'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
